// File: rtl/crc_engine_if.sv
// Word stream into the CRC engine: data/valid/last from the source, ready back from the engine.
interface crc_engine_if #(
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              last;
   logic              ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/crc_engine.sv
// Streaming CRC engine: a word is accepted in ACCEPT, then folded BPC bits per clock
// over N = DATA_W/BPC SHIFT cycles; the final CRC is registered on the last word.
module crc_engine #(
   parameter int unsigned CRC_W  = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BPC    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CRC_W-1:0] poly_i,
   input  logic [CRC_W-1:0] init_i,
   input  logic [CRC_W-1:0] xorout_i,
   input  logic             refin_i,
   input  logic             refout_i,
   crc_engine_if.slave      s_if,
   output logic [CRC_W-1:0] crc_o,
   output logic             crc_valid_o,
   output logic             busy_o
);
   localparam int unsigned N     = DATA_W / BPC;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StAccept, StShift} state_e;

   state_e            state_q, state_d;
   logic [CRC_W-1:0]  poly_q, poly_d;
   logic [CRC_W-1:0]  xorout_q, xorout_d;
   logic [CRC_W-1:0]  crc_q, crc_d;
   logic [CRC_W-1:0]  crc_out_q, crc_out_d;
   logic              refin_q, refin_d;
   logic              refout_q, refout_d;
   logic              last_q, last_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              crc_valid_q, crc_valid_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;

   logic [CRC_W-1:0]  crc_next;
   logic [CRC_W-1:0]  crc_next_rev;
   logic [DATA_W-1:0] data_rev;
   logic              fb;

   // The shift register is stored pre-reflected, so folding always consumes its MSBs.
   always_comb begin
      crc_next = crc_q;
      fb       = 1'b0;
      for (int i = 0; i < int'(BPC); i++) begin
         fb       = crc_next[CRC_W-1] ^ sh_q[DATA_W-1-i];
         crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb ? poly_q : '0);
      end
   end

   always_comb begin
      crc_next_rev = '0;
      data_rev     = '0;
      for (int i = 0; i < int'(CRC_W); i++) crc_next_rev[i] = crc_next[CRC_W-1-i];
      for (int i = 0; i < int'(DATA_W); i++) data_rev[i] = s_if.data[DATA_W-1-i];
   end

   always_comb begin
      state_d     = state_q;
      poly_d      = poly_q;
      xorout_d    = xorout_q;
      refin_d     = refin_q;
      refout_d    = refout_q;
      crc_d       = crc_q;
      crc_out_d   = crc_out_q;
      last_d      = last_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      crc_valid_d = 1'b0;

      unique case (state_q)
         StIdle: ;
         StAccept: begin
            if (s_if.valid && ready_q) begin
               sh_d    = refin_q ? data_rev : s_if.data;
               last_d  = s_if.last;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            crc_d = crc_next;
            sh_d  = sh_q << BPC;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N - 1)) begin
               if (last_q) begin
                  state_d     = StIdle;
                  crc_out_d   = (refout_q ? crc_next_rev : crc_next) ^ xorout_q;
                  crc_valid_d = 1'b1;
               end else begin
                  state_d = StAccept;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // A restart wins over everything, including a completing final word.
      if (start_i) begin
         poly_d      = poly_i;
         xorout_d    = xorout_i;
         refin_d     = refin_i;
         refout_d    = refout_i;
         crc_d       = init_i;
         crc_out_d   = crc_out_q;
         crc_valid_d = 1'b0;
         state_d     = StAccept;
      end

      ready_d = (state_d == StAccept);
      busy_d  = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         poly_q      <= '0;
         xorout_q    <= '0;
         refin_q     <= 1'b0;
         refout_q    <= 1'b0;
         crc_q       <= '0;
         crc_out_q   <= '0;
         last_q      <= 1'b0;
         sh_q        <= '0;
         cnt_q       <= '0;
         crc_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         poly_q      <= poly_d;
         xorout_q    <= xorout_d;
         refin_q     <= refin_d;
         refout_q    <= refout_d;
         crc_q       <= crc_d;
         crc_out_q   <= crc_out_d;
         last_q      <= last_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         crc_valid_q <= crc_valid_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign s_if.ready  = ready_q;
   assign crc_o       = crc_out_q;
   assign crc_valid_o = crc_valid_q;
   assign busy_o      = busy_q;
endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: five configurations share stimulus, one is selected at a time;
// expected CRCs come from constants or a bit-serial reference model.
module tb_crc_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, valid, last, refin, refout;
   logic [31:0] poly, init, xorout, data;
   logic [2:0]  sel;

   int          vectors = 0;
   int          miscompares = 0;
   int          pulses = 0;
   logic [31:0] msg[$];
   logic [31:0] exp_q[$];

   crc_engine_if #(.DATA_W(8))  if0 ();
   crc_engine_if #(.DATA_W(8))  if1 ();
   crc_engine_if #(.DATA_W(32)) if2 ();
   crc_engine_if #(.DATA_W(32)) if3 ();
   crc_engine_if #(.DATA_W(32)) if4 ();

   assign if0.data = data[7:0];
   assign if1.data = data[7:0];
   assign if2.data = data;
   assign if3.data = data;
   assign if4.data = data;
   assign if0.valid = valid && (sel == 3'd0);
   assign if1.valid = valid && (sel == 3'd1);
   assign if2.valid = valid && (sel == 3'd2);
   assign if3.valid = valid && (sel == 3'd3);
   assign if4.valid = valid && (sel == 3'd4);
   assign if0.last = last;
   assign if1.last = last;
   assign if2.last = last;
   assign if3.last = last;
   assign if4.last = last;

   logic [31:0] c0, c2, c3, c4;
   logic [15:0] c1;
   logic [4:0]  cv, bsy, rdy;
   assign rdy = {if4.ready, if3.ready, if2.ready, if1.ready, if0.ready};

   crc_engine #(.CRC_W(32), .DATA_W(8), .BPC(8)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .start_i(start && (sel == 3'd0)), .poly_i(poly),
      .init_i(init), .xorout_i(xorout), .refin_i(refin), .refout_i(refout), .s_if(if0),
      .crc_o(c0), .crc_valid_o(cv[0]), .busy_o(bsy[0]));
   crc_engine #(.CRC_W(16), .DATA_W(8), .BPC(8)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start && (sel == 3'd1)), .poly_i(poly[15:0]),
      .init_i(init[15:0]), .xorout_i(xorout[15:0]), .refin_i(refin), .refout_i(refout),
      .s_if(if1), .crc_o(c1), .crc_valid_o(cv[1]), .busy_o(bsy[1]));
   crc_engine #(.CRC_W(32), .DATA_W(32), .BPC(8)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start && (sel == 3'd2)), .poly_i(poly),
      .init_i(init), .xorout_i(xorout), .refin_i(refin), .refout_i(refout), .s_if(if2),
      .crc_o(c2), .crc_valid_o(cv[2]), .busy_o(bsy[2]));
   crc_engine #(.CRC_W(32), .DATA_W(32), .BPC(1)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(start && (sel == 3'd3)), .poly_i(poly),
      .init_i(init), .xorout_i(xorout), .refin_i(refin), .refout_i(refout), .s_if(if3),
      .crc_o(c3), .crc_valid_o(cv[3]), .busy_o(bsy[3]));
   crc_engine #(.CRC_W(32), .DATA_W(32), .BPC(32)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start && (sel == 3'd4)), .poly_i(poly),
      .init_i(init), .xorout_i(xorout), .refin_i(refin), .refout_i(refout), .s_if(if4),
      .crc_o(c4), .crc_valid_o(cv[4]), .busy_o(bsy[4]));

   logic        obs_ready, obs_cv, obs_busy;
   logic [31:0] obs_crc;
   always_comb begin
      obs_ready = 1'b0;
      obs_cv    = 1'b0;
      obs_busy  = 1'b0;
      obs_crc   = '0;
      unique case (sel)
         3'd0: begin obs_ready = rdy[0]; obs_cv = cv[0]; obs_busy = bsy[0]; obs_crc = c0; end
         3'd1: begin
            obs_ready = rdy[1]; obs_cv = cv[1]; obs_busy = bsy[1]; obs_crc = {16'h0, c1};
         end
         3'd2: begin obs_ready = rdy[2]; obs_cv = cv[2]; obs_busy = bsy[2]; obs_crc = c2; end
         3'd3: begin obs_ready = rdy[3]; obs_cv = cv[3]; obs_busy = bsy[3]; obs_crc = c3; end
         default: begin obs_ready = rdy[4]; obs_cv = cv[4]; obs_busy = bsy[4]; obs_crc = c4; end
      endcase
   end

   always @(posedge clk) if (|cv) pulses <= pulses + 1;

   function automatic logic [31:0] crc_model(input int cw, input int dw);
      logic [31:0] mask, r, o;
      mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
      r = init & mask;
      foreach (msg[k]) begin
         for (int i = 0; i < dw; i++) begin
            logic b, f;
            b = refin ? msg[k][i] : msg[k][dw-1-i];
            f = r[cw-1] ^ b;
            r = ((r << 1) & mask) ^ (f ? (poly & mask) : 32'h0);
         end
      end
      o = r;
      if (refout) begin
         o = '0;
         for (int i = 0; i < cw; i++) o[i] = r[cw-1-i];
      end
      return (o ^ xorout) & mask;
   endfunction

   task automatic set_cfg(input logic [31:0] p, input logic [31:0] i, input logic [31:0] x,
                          input logic ri, input logic ro);
      poly = p; init = i; xorout = x; refin = ri; refout = ro;
   endtask

   task automatic set_bytes(input string s);
      msg.delete();
      for (int i = 0; i < s.len(); i++) msg.push_back({24'h0, s[i]});
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic l);
      int t;
      t = 0;
      valid = 1'b1;
      while (!obs_ready) begin
         data = $urandom;
         last = 1'($urandom_range(1));
         @(negedge clk);
         t++;
         if (t > 300) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: ready_o low for %0d cycles, required high", t);
            valid = 1'b0;
            return;
         end
      end
      data = w;
      last = l;
      @(negedge clk);
   endtask

   task automatic wait_crc(output int lat, output logic [31:0] got);
      lat = 0;
      got = 'x;
      while (!obs_cv) begin
         @(negedge clk);
         lat++;
         if (lat > 300) begin
            vectors++; miscompares++;
            $display("FAIL crc_valid_timeout: no pulse in %0d cycles, required one", lat);
            return;
         end
      end
      got = obs_crc;
   endtask

   // Config inputs are scrambled after start to show they are only sampled at start.
   task automatic run_msg(input bit gaps, output int lat, output logic [31:0] got);
      logic [31:0] sp, si, sx;
      logic        sri, sro;
      int          g;
      sp = poly; si = init; sx = xorout; sri = refin; sro = refout;
      do_start();
      set_cfg($urandom, $urandom, $urandom, ~sri, ~sro);
      for (int k = 0; k < msg.size(); k++) begin
         send_word(msg[k], k == msg.size() - 1);
         if (gaps && k != msg.size() - 1) begin
            g = $urandom_range(2);
            if (g != 0) begin
               valid = 1'b0;
               repeat (g) @(negedge clk);
            end
         end
      end
      valid = gaps;
      data  = $urandom;
      wait_crc(lat, got);
      valid = 1'b0;
      set_cfg(sp, si, sx, sri, sro);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (cv !== 5'b0) begin miscompares++; $display("FAIL reset_crc_valid: %b, required 0", cv); end
      vectors++;
      if (rdy !== 5'b0) begin miscompares++; $display("FAIL reset_ready: %b, required 0", rdy); end
      vectors++;
      if (bsy !== 5'b0) begin miscompares++; $display("FAIL reset_busy: %b, required 0", bsy); end
      vectors++;
      if ({c0, c1, c2, c3, c4} !== 144'h0) begin
         miscompares++;
         $display("FAIL reset_crc: %h %h %h %h %h, required 0", c0, c1, c2, c3, c4);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_crc32();
      int lat; logic [31:0] got, e;
      sel = 3'd0;
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      set_bytes("123456789");
      exp_q.push_back(32'hCBF43926);
      run_msg(1'b0, lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL crc32: crc_o=%h, required %h", got, e); end
      vectors++;
      if (lat != 1) begin miscompares++; $display("FAIL crc32_latency: %0d, required 1", lat); end
      @(negedge clk);
      vectors++;
      if (obs_cv !== 1'b0 || obs_crc !== e) begin
         miscompares++;
         $display("FAIL crc32_hold: crc_valid_o=%b crc_o=%h, required 0 and %h", obs_cv, obs_crc, e);
      end
   endtask

   task automatic test_crc16();
      int lat; logic [31:0] got, e;
      sel = 3'd1;
      set_cfg(32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0);
      set_bytes("123456789");
      exp_q.push_back(32'h29B1);
      run_msg(1'b0, lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL crc16: crc_o=%h, required %h", got, e); end
   endtask

   task automatic test_mpeg2();
      int lat, cnt; logic [31:0] got, e;
      sel = 3'd2;
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      msg.delete();
      msg.push_back(32'h31323334);
      msg.push_back(32'h35363738);
      exp_q.push_back(crc_model(32, 32));
      do_start();
      send_word(msg[0], 1'b0);
      valid = 1'b0;
      cnt = 0;
      while (!obs_ready && cnt < 50) begin @(negedge clk); cnt++; end
      vectors++;
      if (cnt != 4) begin miscompares++; $display("FAIL mpeg2_ready_low: %0d cycles, required 4", cnt); end
      send_word(msg[1], 1'b1);
      valid = 1'b0;
      wait_crc(lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL mpeg2_words: crc_o=%h, required %h", got, e); end
      vectors++;
      if (lat != 4) begin miscompares++; $display("FAIL mpeg2_latency: %0d, required 4", lat); end
      sel = 3'd0;
      set_bytes("12345678");
      exp_q.push_back(crc_model(32, 8));
      run_msg(1'b0, lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL mpeg2_bytes8: crc_o=%h, required %h", got, e); end
      set_bytes("123456789");
      exp_q.push_back(32'h0376E6E7);
      run_msg(1'b0, lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL mpeg2_bytes9: crc_o=%h, required %h", got, e); end
   endtask

   task automatic test_abort();
      int lat, p0; logic [31:0] got, e;
      sel = 3'd0;
      set_cfg(32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b0);
      msg.delete();
      for (int i = 0; i < 5; i++) msg.push_back({24'h0, 8'($urandom)});
      @(negedge clk);
      p0 = pulses;
      do_start();
      send_word(msg[0], 1'b0);
      send_word(msg[1], 1'b0);
      // Word 2 is now shifting; run_msg restarts on that edge.
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      set_bytes("123456789");
      exp_q.push_back(32'hCBF43926);
      run_msg(1'b0, lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL abort_crc: crc_o=%h, required %h", got, e); end
      repeat (4) @(negedge clk);
      vectors++;
      if (pulses - p0 != 1) begin
         miscompares++;
         $display("FAIL abort_pulses: %0d crc_valid_o pulses, required 1", pulses - p0);
      end
   endtask

   task automatic test_start_on_final();
      int p0;
      sel = 3'd0;
      set_cfg(32'h04C11DB7, 32'h0, 32'h0, 1'b0, 1'b0);
      set_bytes("12");
      p0 = pulses;
      do_start();
      send_word(msg[0], 1'b0);
      send_word(msg[1], 1'b1);
      start = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (obs_cv !== 1'b0 || obs_crc !== 32'hCBF43926) begin
         miscompares++;
         $display("FAIL start_on_final: crc_valid_o=%b crc_o=%h, required 0 and cbf43926",
                  obs_cv, obs_crc);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (pulses != p0 || obs_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL start_on_final_state: pulses=%0d ready_o=%b, required %0d and 1",
                  pulses, obs_ready, p0);
      end
   endtask

   task automatic test_reset_mid();
      int lat, p0; logic [31:0] got, e; bit bad;
      sel = 3'd2;
      set_cfg(32'h04C11DB7, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      msg.delete();
      msg.push_back(32'hDEADBEEF);
      msg.push_back(32'h01234567);
      do_start();
      send_word(msg[0], 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (obs_crc !== 32'h0 || obs_cv !== 1'b0 || obs_ready !== 1'b0 || obs_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: crc_o=%h crc_valid_o=%b ready_o=%b busy_o=%b, required all 0",
                  obs_crc, obs_cv, obs_ready, obs_busy);
      end
      p0 = pulses;
      bad = 1'b0;
      valid = 1'b1;
      last = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data = $urandom;
         @(negedge clk);
         if (obs_ready || obs_busy || obs_cv) bad = 1'b1;
      end
      valid = 1'b0;
      vectors++;
      if (bad || pulses != p0) begin
         miscompares++;
         $display("FAIL reset_mid_ignore: activity=%b pulses=%0d, required 0 and %0d", bad, pulses, p0);
      end
      exp_q.push_back(crc_model(32, 32));
      run_msg(1'b0, lat, got);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin miscompares++; $display("FAIL reset_recover: crc_o=%h, required %h", got, e); end
   endtask

   task automatic test_random(input logic [2:0] s, input int count);
      int lat, len; logic [31:0] got, e;
      sel = s;
      for (int m = 0; m < count; m++) begin
         set_cfg($urandom, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
         msg.delete();
         len = $urandom_range(4, 1);
         for (int i = 0; i < len; i++) msg.push_back($urandom);
         exp_q.push_back(crc_model(32, 32));
         run_msg(1'b1, lat, got);
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL random_sel%0d_msg%0d: crc_o=%h, required %h", s, m, got, e);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; data = '0; sel = 3'd0;
      set_cfg(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      test_reset();
      test_crc32();
      test_crc16();
      test_mpeg2();
      test_abort();
      test_start_on_final();
      test_reset_mid();
      test_random(3'd3, 334);
      test_random(3'd2, 333);
      test_random(3'd4, 333);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
